// File: rtl/cdb_arbiter.sv
// Writeback arbiter: per-source result FIFOs, round-robin selection of up to CDB_W results per cycle onto the CDB.
// Optional same-cycle bypass of empty FIFOs is enabled with `define CDB_ARB_BYPASS_EN.

module cdb_src_fifo #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [DATA_W-1:0] val_i,
  output logic              ready_o,
  output logic              nonempty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DATA_W-1:0] val_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][TAG_W-1:0]  tag_mem_q;
  logic [DEPTH-1:0][DATA_W-1:0] val_mem_q;
  logic [PTR_W-1:0]             wr_q, rd_q;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
    else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: heads are only observed while the count is nonzero.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      tag_mem_q[wr_q] <= tag_i;
      val_mem_q[wr_q] <= val_i;
    end
  end

  assign ready_o    = (cnt_q < CNT_W'(DEPTH));
  assign nonempty_o = |cnt_q;
  assign tag_o      = tag_mem_q[rd_q];
  assign val_o      = val_mem_q[rd_q];
endmodule

module cdb_arbiter #(
  parameter int NUM_SRC    = 6,
  parameter int CDB_W      = 4,
  parameter int TAG_W      = 6,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2,
  localparam int OCC_W     = $clog2(NUM_SRC*FIFO_DEPTH+1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic [NUM_SRC-1:0]             fu_valid,
  output logic [NUM_SRC-1:0]             fu_ready,
  input  logic [NUM_SRC-1:0][TAG_W-1:0]  fu_tag,
  input  logic [NUM_SRC-1:0][DATA_W-1:0] fu_val,
  output logic [CDB_W-1:0]               cdb_valid,
  output logic [CDB_W-1:0][TAG_W-1:0]    cdb_tag,
  output logic [CDB_W-1:0][DATA_W-1:0]   cdb_val,
  output logic [OCC_W-1:0]               occupancy_o
);
  localparam int PTR_W = $clog2(NUM_SRC);
  localparam int LN_W  = $clog2(CDB_W + 1);
  localparam int LI_W  = (CDB_W > 1) ? $clog2(CDB_W) : 1;

  logic [NUM_SRC-1:0]             nonempty, elig, grant, push, pop;
  logic [NUM_SRC-1:0][TAG_W-1:0]  head_tag;
  logic [NUM_SRC-1:0][DATA_W-1:0] head_val;

  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [OCC_W-1:0]             occ_q, occ_d;
  logic [CDB_W-1:0]             lane_vld;
  logic [CDB_W-1:0][TAG_W-1:0]  lane_tag;
  logic [CDB_W-1:0][DATA_W-1:0] lane_val;

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx, last;
  logic [LN_W-1:0]  nl;
  logic             any;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    cdb_src_fifo #(.TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_i   (flush_i),
      .push_i    (push[s]),
      .pop_i     (pop[s]),
      .tag_i     (fu_tag[s]),
      .val_i     (fu_val[s]),
      .ready_o   (fu_ready[s]),
      .nonempty_o(nonempty[s]),
      .tag_o     (head_tag[s]),
      .val_o     (head_val[s])
    );
  end

`ifdef CDB_ARB_BYPASS_EN
  // An empty FIFO always has room, so a valid input there is a legal push and may go straight out.
  assign elig = nonempty | (fu_valid & ~{NUM_SRC{flush_i}});
  assign push = fu_valid & fu_ready & ~{NUM_SRC{flush_i}} & ~(grant & ~nonempty);
`else
  assign elig = nonempty;
  assign push = fu_valid & fu_ready & ~{NUM_SRC{flush_i}};
`endif
  assign pop = grant & nonempty;

  always_comb begin
    grant    = '0;
    lane_vld = '0;
    lane_tag = '0;
    lane_val = '0;
    sum      = '0;
    idx      = '0;
    nl       = '0;
    last     = rr_ptr_q;
    any      = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_SRC)) sum = sum - (PTR_W+1)'(NUM_SRC);
      idx = sum[PTR_W-1:0];
      if (elig[idx] && (nl < LN_W'(CDB_W))) begin
        grant[idx]              = 1'b1;
        lane_vld[nl[LI_W-1:0]]  = 1'b1;
        lane_tag[nl[LI_W-1:0]]  = nonempty[idx] ? head_tag[idx] : fu_tag[idx];
        lane_val[nl[LI_W-1:0]]  = nonempty[idx] ? head_val[idx] : fu_val[idx];
        nl   = nl + 1'b1;
        last = idx;
        any  = 1'b1;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (any) rr_ptr_d = (last == PTR_W'(NUM_SRC-1)) ? '0 : last + 1'b1;
  end

  always_comb begin
    occ_d = occ_q;
    for (int s = 0; s < NUM_SRC; s++)
      occ_d = occ_d + OCC_W'(push[s]) - OCC_W'(pop[s]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_val   <= '0;
      rr_ptr_q  <= '0;
      occ_q     <= '0;
    end else if (flush_i) begin
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_val   <= '0;
      rr_ptr_q  <= '0;
      occ_q     <= '0;
    end else begin
      cdb_valid <= lane_vld;
      cdb_tag   <= lane_tag;
      cdb_val   <= lane_val;
      rr_ptr_q  <= rr_ptr_d;
      occ_q     <= occ_d;
    end
  end

  assign occupancy_o = occ_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single push, oversubscription, flush, backpressure, bypass.
module tb_cdb_arbiter;
  logic             clk, rst_n, flush_i;
  logic [5:0]       fu_valid, fu_ready;
  logic [5:0][5:0]  fu_tag;
  logic [5:0][31:0] fu_val;
  logic [3:0]       cdb_valid;
  logic [3:0][5:0]  cdb_tag;
  logic [3:0][31:0] cdb_val;
  logic [3:0]       occupancy_o;

  int n_tests = 0;
  int n_fail  = 0;

  cdb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_tag(fu_tag), .fu_val(fu_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .occupancy_o(occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] v, input int tbase, input int vbase);
    fu_valid = v;
    for (int s = 0; s < 6; s++) begin
      fu_tag[s] = 6'(tbase + s);
      fu_val[s] = 32'(vbase + s);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; fu_valid = '0; fu_tag = '0; fu_val = '0;
    repeat (2) tick();
    chk("rst_valid", 64'(cdb_valid), 64'h0);
    chk("rst_ready", 64'(fu_ready), 64'h3f);
    chk("rst_occ", 64'(occupancy_o), 64'h0);
    rst_n = 1'b1;
    tick();

`ifndef CDB_ARB_BYPASS_EN
    // Oversubscription: all six push, rr starts at 0
    drive(6'b111111, 10, 100);
    tick();
    fu_valid = '0;
    chk("os_occ6", 64'(occupancy_o), 64'd6);
    chk("os_ready", 64'(fu_ready), 64'h3f);
    tick();
    chk("os_v0", 64'(cdb_valid), 64'hf);
    chk("os_t0", 64'(cdb_tag), {40'h0, 6'd13, 6'd12, 6'd11, 6'd10});
    chk("os_occ2", 64'(occupancy_o), 64'd2);
    tick();
    chk("os_v1", 64'(cdb_valid), 64'h3);
    chk("os_t1_l0", 64'(cdb_tag[0]), 64'd14);
    chk("os_t1_l1", 64'(cdb_tag[1]), 64'd15);
    chk("os_v1_l1", 64'(cdb_val[1]), 64'd105);
    chk("os_t1_l2", 64'(cdb_tag[2]), 64'd0);
    chk("os_occ0", 64'(occupancy_o), 64'd0);
    tick();
    chk("empty_v", 64'(cdb_valid), 64'h0);

    // Single push from src2
    fu_valid = 6'b000100; fu_tag[2] = 6'd5; fu_val[2] = 32'hDEAD;
    tick();
    fu_valid = '0;
    chk("sp_occ1", 64'(occupancy_o), 64'd1);
    chk("sp_v_c1", 64'(cdb_valid), 64'h0);
    tick();
    chk("sp_v_c2", 64'(cdb_valid), 64'h1);
    chk("sp_tag", 64'(cdb_tag[0]), 64'd5);
    chk("sp_val", 64'(cdb_val[0]), 64'hDEAD);
    tick();
    chk("sp_v_c3", 64'(cdb_valid), 64'h0);

    // Flush with 5 buffered and a concurrent src1 push
    drive(6'b111101, 60, 600);
    tick();
    chk("fl_occ5", 64'(occupancy_o), 64'd5);
    flush_i = 1'b1; fu_valid = 6'b000010;
    tick();
    flush_i = 1'b0; fu_valid = '0;
    chk("fl_v", 64'(cdb_valid), 64'h0);
    chk("fl_occ", 64'(occupancy_o), 64'd0);
    chk("fl_ready", 64'(fu_ready), 64'h3f);
    tick();
    chk("fl_v2", 64'(cdb_valid), 64'h0);
    tick();
    chk("fl_v3", 64'(cdb_valid), 64'h0);
    // rr back at 0: src0 ahead of src5
    fu_valid = 6'b100001; fu_tag[0] = 6'd20; fu_val[0] = 32'd200; fu_tag[5] = 6'd25; fu_val[5] = 32'd250;
    tick();
    fu_valid = '0;
    tick();
    chk("fl_rr_v", 64'(cdb_valid), 64'h3);
    chk("fl_rr_t0", 64'(cdb_tag[0]), 64'd20);
    chk("fl_rr_t1", 64'(cdb_tag[1]), 64'd25);
    tick();

    // rr wrapped to 0; a single src0 grant moves it to 1
    fu_valid = 6'b000001; fu_tag[0] = 6'd7; fu_val[0] = 32'd7;
    tick();
    fu_valid = '0;
    tick();
    chk("wrap_v", 64'(cdb_valid), 64'h1);
    chk("wrap_t", 64'(cdb_tag[0]), 64'd7);
    tick();

    // Backpressure on src0 behind sources 1..4
    drive(6'b011111, 30, 300);
    tick();
    drive(6'b011111, 40, 400);
    tick();
    chk("bp_ready", 64'(fu_ready), 64'h3e);
    chk("bp_v0", 64'(cdb_valid), 64'hf);
    chk("bp_t0", 64'(cdb_tag), {40'h0, 6'd34, 6'd33, 6'd32, 6'd31});
    chk("bp_occ6", 64'(occupancy_o), 64'd6);
    fu_valid = 6'b000001; fu_tag[0] = 6'd63; fu_val[0] = 32'd999;
    tick();
    fu_valid = '0;
    chk("bp_v1", 64'(cdb_valid), 64'hf);
    chk("bp_t1", 64'(cdb_tag), {40'h0, 6'd43, 6'd42, 6'd41, 6'd30});
    chk("bp_occ2", 64'(occupancy_o), 64'd2);
    tick();
    chk("bp_v2", 64'(cdb_valid), 64'h3);
    chk("bp_t2_l0", 64'(cdb_tag[0]), 64'd44);
    chk("bp_t2_l1", 64'(cdb_tag[1]), 64'd40);
    chk("bp_val2", 64'(cdb_val[1]), 64'd400);
    tick();
    chk("bp_drop", 64'(cdb_valid), 64'h0);
    chk("bp_occ0", 64'(occupancy_o), 64'd0);
`else
    // Bypass: src3 into an empty arbiter appears next cycle
    fu_valid = 6'b001000; fu_tag[3] = 6'd5; fu_val[3] = 32'hDEAD;
    tick();
    fu_valid = '0;
    chk("byp_v", 64'(cdb_valid), 64'h1);
    chk("byp_tag", 64'(cdb_tag[0]), 64'd5);
    chk("byp_val", 64'(cdb_val[0]), 64'hDEAD);
    chk("byp_occ", 64'(occupancy_o), 64'd0);
    tick();
    chk("byp_v2", 64'(cdb_valid), 64'h0);
    // Six at once: four bypass, two buffered
    drive(6'b111111, 10, 100);
    tick();
    fu_valid = '0;
    chk("byp_os_v", 64'(cdb_valid), 64'hf);
    chk("byp_os_occ", 64'(occupancy_o), 64'd2);
    tick();
    chk("byp_os_v2", 64'(cdb_valid), 64'h3);
    tick();
`endif

    // Async reset mid-cycle while a lane is valid
    fu_valid = 6'b001000; fu_tag[3] = 6'd9; fu_val[3] = 32'd9;
    tick();
    fu_valid = '0;
`ifndef CDB_ARB_BYPASS_EN
    tick();
`endif
    chk("ar_pre_v", 64'(cdb_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_v", 64'(cdb_valid), 64'h0);
    chk("ar_ready", 64'(fu_ready), 64'h3f);
    chk("ar_occ", 64'(occupancy_o), 64'h0);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Writeback stage directly downstream of the issue stage's ALU ports and the other functional units (FUs).
- Buffers completed results per source and arbitrates up to CDB_W results per cycle onto the common data bus.
- Its cdb_valid/cdb_tag/cdb_val outputs feed the reservation-station wakeup inputs and the ROB.
- Round-robin fairness across sources; per-source credit backpressure via fu_ready.

Parameters:
- NUM_SRC, 6, number of result producers (4 ALUs, LSU, MDU); source index = fixed priority position for round-robin.
- CDB_W, 4, number of broadcast lanes per cycle.
- TAG_W, 6, destination tag width.
- DATA_W, 32, result data width.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, >=2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous pipeline flush.
- fu_valid  in  NUM_SRC  result valid per source.
- fu_ready  out  NUM_SRC  source may push this cycle.
- fu_tag  in  TAG_W x NUM_SRC  destination tag per source.
- fu_val  in  DATA_W x NUM_SRC  result value per source.
- cdb_valid  out  CDB_W  lane broadcast valid (registered).
- cdb_tag  out  TAG_W x CDB_W  lane tag (registered).
- cdb_val  out  DATA_W x CDB_W  lane value (registered).
- occupancy_o  out  $clog2(NUM_SRC*FIFO_DEPTH+1)  total buffered entries, for debug/perf.

Behaviour:
- Reset (rst_n=0, async): all FIFO counts/pointers 0, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_val=0, occupancy_o=0. fu_ready is all-ones while counts are 0.
- Push: fu_ready[s] = (count[s] < FIFO_DEPTH), derived from the registered count only. A same-cycle pop does not raise fu_ready.
  - Push occurs when fu_valid[s] & fu_ready[s]. fu_valid with fu_ready=0 is a protocol error; the entry is dropped, no state change.
- Select (combinational, each cycle): scan sources starting at rr_ptr, wrapping modulo NUM_SRC, and grant the first up to CDB_W sources with count>0.
  - Lane assignment is compacted in scan order: first granted source → lane 0, and so on. Unused lanes get valid=0 and tag/val=0.
- Pop: each granted source pops its head at the clock edge. Simultaneous push and pop on the same source: count unchanged, both pointers advance.
- rr_ptr update: (index of last granted source + 1) mod NUM_SRC. Unchanged if no grant. Wraps at NUM_SRC-1 → 0.
- Output register: cdb_* load the selected heads each edge. Each lane is valid for exactly one cycle per entry; no output stall, since consumers always accept.
- Latency: push at edge ending cycle t → head in cycle t+1 → cdb_valid visible in cycle t+2, provided the source is granted.
- Ordering: entries from the same source broadcast in push order. No ordering guarantee across sources.
- Full: all FIFOs full with CDB_W < NUM_SRC → exactly CDB_W pops per cycle. The round-robin guarantees every source is served within ceil(NUM_SRC/CDB_W) cycles.
- Empty: all counts 0 → next-cycle cdb_valid=0.
- flush_i=1: at the edge, clear all counts/pointers, set cdb_valid=0, set rr_ptr=0.
  - Pushes in the flush cycle are discarded.
  - cdb outputs already registered from the previous cycle remain visible during the flush cycle.
- occupancy_o: registered sum of counts, updated with the FIFO state.

Optional Feature:
- Macro CDB_ARB_BYPASS_EN.
- Defined: a source whose FIFO is empty (count=0) and has fu_valid=1 is eligible for selection in the same cycle.
  - If granted, the result goes directly to the output register without being written to the FIFO. Latency drops to push cycle t → cdb_valid in t+1.
  - Scan order and lane compaction are unchanged.
  - If not granted, the entry is written to the FIFO as normal.
- Undefined: FIFO path only, 2-cycle latency as specified above.

Test Plan:
- Reset then idle: rst_n low mid-cycle → cdb_valid=0 immediately; fu_ready=6'b111111; occupancy_o=0.
- Single push: src2 pushes tag=5, val=0xDEAD at cycle 0 → cycle 2 shows cdb_valid=4'b0001, cdb_tag[0]=5, cdb_val[0]=0xDEAD; cycle 3 shows cdb_valid=0.
- Oversubscription: all 6 sources push once in the same cycle → first broadcast cycle serves srcs 0-3 on lanes 0-3 and rr_ptr becomes 4. Next cycle serves srcs 4,5 on lanes 0,1.
- Backpressure: src0 pushes 2 entries while blocked by 4 busier sources ahead in rr order → fu_ready[0]=0. A third push attempt is dropped. Exactly 2 src0 broadcasts occur, in push order.
- Flush: 5 entries buffered, flush_i pulsed with a concurrent src1 push → next cycle cdb_valid=0, occupancy_o=0, rr_ptr=0, and the src1 entry is never broadcast.
- Bypass (CDB_ARB_BYPASS_EN defined): src3 pushes into an empty arbiter at cycle 0 → cdb_valid[0]=1 at cycle 1 and occupancy_o stays 0.
